jtframe_kabuki_pipe: RTL
========================

Name: jtframe_kabuki_pipe

Overview:
- Pipelined, parametrised Kabuki-style Z80 opcode/data decryptor for CPS 1.5-class sound subsystems; sits between the Z80 ROM read path (SDRAM or BRAM) and the CPU data bus.
- Adds atomic key load with a byte counter, a key-valid flag, NBANK selectable key banks, and a fixed-latency valid pipeline with bypass.
- Decoded byte is registered, so the block closes timing at the SDRAM clock.

Parameters:
- AW, 16, CPU address width (>=16; only addr[15:0] enters the cipher).
- DATA_XOR, 16'h1fc0, constant XORed into the address for data (non-M1) reads.
- NBANK, 1, number of independent 88-bit key banks (1..4).
- KEYB, 11, key bytes per bank (fixed by the cipher; parameter exists for checks only).

Ports:
- clk  in  1  system clock, same as SDRAM clock.
- rst  in  1  synchronous, active-high reset.
- prog_clr  in  1  restart key loading for bank prog_bank: counter=0, staging cleared.
- prog_bank  in  max(1,$clog2(NBANK))  bank being loaded.
- prog_we  in  1  strobe: shift prog_data into staging.
- prog_data  in  8  key byte; first byte loaded ends in key[87:80].
- key_sel  in  max(1,$clog2(NBANK))  bank used for decoding; sampled in stage 1.
- en  in  1  decryption enable; 0 = bypass.
- req  in  1  decode request valid.
- m1_n  in  1  0 = opcode fetch, 1 = data read.
- addr  in  AW  read address.
- din  in  8  raw ROM byte.
- dout  out  8  decoded byte.
- dout_ok  out  1  dout valid, one pulse per req.
- key_ok  out  NBANK  per-bank "complete key committed" flag.

Behaviour:
- Reset: dout=0, dout_ok=0, key_ok=0, all key banks, staging and counters = 0, pipeline valids cleared. A req issued in the reset cycle or still in flight is dropped; no dout_ok.
- Key load:
  - prog_we shifts prog_data into staging[prog_bank] at the LSB and increments cnt.
  - When cnt reaches KEYB-1 with prog_we active, the full staging word is copied to bank[prog_bank] next cycle, key_ok[bank] is set and cnt returns to 0.
  - Extra bytes start a new load.
  - A partial load never alters the active bank.
  - prog_clr has priority over prog_we in the same cycle.
- Key layout: {s1[31:0], s2[31:0], akey[15:0], xkey[7:0]}.
- Stage 1 (cycle N+1 after req at N) registers:
  - hit = m1_n ? ((a ^ DATA_XOR) + akey + 1) : (a + akey), where a = addr[15:0]. All arithmetic is modulo 2^16.
  - din, m1_n, selected key, and the bypass flag = !en | !key_ok[key_sel].
- Stage 2 (cycle N+2): dout and dout_ok registered.
  - Latency is exactly 2 cycles.
  - The pipeline accepts one req per cycle with no stall.
  - Bypass gives dout = din.
- Cipher: rol(x) = {x[6:0],x[7]}. Pair p covers bits [2p+1:2p] and is swapped when h[sel].
  - swapA(d,k,h): pair3 sel=k[14:12], pair2 k[10:8], pair1 k[6:4], pair0 k[2:0].
  - swapB: pair3 k[2:0], pair2 k[6:4], pair1 k[10:8], pair0 k[14:12].
  - Sequence, with lo=hit[7:0] and hi=hit[15:8]:
    1. d=swapA(d,s1[15:0],lo)
    2. rol
    3. swapB(s1[31:16],lo)
    4. ^xkey
    5. rol
    6. swapB(s2[15:0],hi)
    7. rol
    8. swapA(s2[31:16],hi)
- Simultaneous events:
  - A bank commit in the same cycle as stage 1 sampling that bank: stage 1 uses the old key.
  - key_sel changes affect only requests sampled after the change.

Decomposition:
- Package jtframe_kabuki_pkg holds:
  - Constants KEY_W=88 and KEYB=11.
  - Field offsets for s1, s2, akey and xkey.
  - Pure functions swapA, swapB and rol.
- Sub-module jtframe_kabuki_keys holds the per-bank staging, counter, commit and key_ok logic.
- The top level holds the two-stage datapath.

Test Plan:
- Zero key committed, en=1, req m1_n=0 addr=0000 din=01 -> dout=08 (three rotates only) with dout_ok two cycles later.
- Zero key, m1_n=1 addr=0000 din=01 -> hit=1fc1, every pair swaps, dout=80.
- en=0, or key_ok=0 after reset, din=A5 -> dout=A5 at latency 2. Back-to-back reqs on consecutive cycles -> consecutive dout_ok pulses, in order.
- Load 5 bytes then decode -> old key result and key_ok unchanged. Then prog_clr and 11 bytes -> key_ok=1 one cycle after the last byte. Compare dout against the software model for the xkey=FF, akey=0001 case.
- NBANK=2: bank0 zero key, bank1 xkey=FF; toggle key_sel per req with din=01, m1_n=0, addr=0 -> dout alternates 08 / F7.
- rst asserted with two reqs in flight -> no dout_ok, dout=00, key_ok=0.

Source files
------------

// File: rtl/jtframe_kabuki_pkg.sv
// Kabuki key layout constants and the byte cipher primitives shared by the
// key store and the decode pipeline.
package jtframe_kabuki_pkg;

    localparam int KEY_W    = 88;
    localparam int KEYB     = 11;
    localparam int XKEY_LSB = 0;
    localparam int AKEY_LSB = 8;
    localparam int S2_LSB   = 24;
    localparam int S1_LSB   = 56;

    function automatic logic [7:0] rol(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    function automatic logic [1:0] pair_sw(input logic [1:0] p, input logic s);
        return s ? {p[0], p[1]} : p;
    endfunction

    // Only three of every four key bits act as bit selects into h.
    function automatic logic [7:0] swap_a(input logic [7:0] d, input logic [15:0] k,
                                          input logic [7:0] h);
        logic unused_k;
        unused_k = ^{k[15], k[11], k[7], k[3]};
        return {pair_sw(d[7:6], h[k[14:12]]), pair_sw(d[5:4], h[k[10:8]]),
                pair_sw(d[3:2], h[k[6:4]]),   pair_sw(d[1:0], h[k[2:0]])};
    endfunction

    function automatic logic [7:0] swap_b(input logic [7:0] d, input logic [15:0] k,
                                          input logic [7:0] h);
        logic unused_k;
        unused_k = ^{k[15], k[11], k[7], k[3]};
        return {pair_sw(d[7:6], h[k[2:0]]),  pair_sw(d[5:4], h[k[6:4]]),
                pair_sw(d[3:2], h[k[10:8]]), pair_sw(d[1:0], h[k[14:12]])};
    endfunction

    function automatic logic [7:0] kabuki_cipher(input logic [7:0]  d,
                                                 input logic [31:0] s1,
                                                 input logic [31:0] s2,
                                                 input logic [7:0]  xkey,
                                                 input logic [15:0] hit);
        logic [7:0] x;
        x = swap_a(d, s1[15:0], hit[7:0]);
        x = rol(x);
        x = swap_b(x, s1[31:16], hit[7:0]);
        x = x ^ xkey;
        x = rol(x);
        x = swap_b(x, s2[15:0], hit[15:8]);
        x = rol(x);
        x = swap_a(x, s2[31:16], hit[15:8]);
        return x;
    endfunction

endpackage

// File: rtl/jtframe_kabuki_pipe_keys.sv
// Per-bank key staging: bytes shift in at the LSB and the whole word is
// committed atomically once the last byte arrives, so decoding never sees a partial key.
module jtframe_kabuki_pipe_keys #(
    parameter int NBANK = 1,
    parameter int TC    = 11,
    parameter int BW    = 1
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_prog_clr,
    input  logic [BW-1:0]                             i_prog_bank,
    input  logic                                      i_prog_we,
    input  logic [7:0]                                i_prog_data,
    output logic [NBANK*jtframe_kabuki_pkg::KEY_W-1:0] o_keys,
    output logic [NBANK-1:0]                          o_key_ok
);
    import jtframe_kabuki_pkg::*;

    logic [KEY_W-1:0] r_stage [NBANK];
    logic [KEY_W-1:0] r_bank  [NBANK];
    logic [3:0]       r_cnt   [NBANK];
    logic [NBANK-1:0] r_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < NBANK; b++) begin
                r_stage[b] <= '0;
                r_bank[b]  <= '0;
                r_cnt[b]   <= '0;
            end
            r_ok <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (i_prog_bank == BW'(b)) begin
                    if (i_prog_clr) begin
                        r_cnt[b]   <= '0;
                        r_stage[b] <= '0;
                    end else if (i_prog_we) begin
                        r_stage[b] <= {r_stage[b][KEY_W-9:0], i_prog_data};
                        if (r_cnt[b] == 4'(TC-1)) begin
                            r_bank[b] <= {r_stage[b][KEY_W-9:0], i_prog_data};
                            r_ok[b]   <= 1'b1;
                            r_cnt[b]  <= '0;
                        end else begin
                            r_cnt[b] <= r_cnt[b] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_out
        assign o_keys[g*KEY_W +: KEY_W] = r_bank[g];
    end
    assign o_key_ok = r_ok;

endmodule

// File: rtl/jtframe_kabuki_pipe.sv
// Two-stage Kabuki decryptor between the Z80 ROM path and the CPU data bus:
// stage 1 computes the address hash and latches the key, stage 2 registers the byte.
module jtframe_kabuki_pipe #(
    parameter int          AW       = 16,
    parameter logic [15:0] DATA_XOR = 16'h1fc0,
    parameter int          NBANK    = 1,
    parameter int          KEYB     = 11,
    localparam int         BW       = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_prog_clr,
    input  logic [BW-1:0]    i_prog_bank,
    input  logic             i_prog_we,
    input  logic [7:0]       i_prog_data,
    input  logic [BW-1:0]    i_key_sel,
    input  logic             i_en,
    input  logic             i_req,
    input  logic             i_m1_n,
    input  logic [AW-1:0]    i_addr,
    input  logic [7:0]       i_din,
    output logic [7:0]       o_dout,
    output logic             o_dout_ok,
    output logic [NBANK-1:0] o_key_ok
);
    import jtframe_kabuki_pkg::*;

    logic [NBANK*KEY_W-1:0] w_keys;
    logic [NBANK-1:0]       w_key_ok;

    jtframe_kabuki_pipe_keys #(
        .NBANK (NBANK),
        .TC    (KEYB),
        .BW    (BW)
    ) u_keys (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_prog_clr  (i_prog_clr),
        .i_prog_bank (i_prog_bank),
        .i_prog_we   (i_prog_we),
        .i_prog_data (i_prog_data),
        .o_keys      (w_keys),
        .o_key_ok    (w_key_ok)
    );

    // Pad to a power of two so any key_sel value indexes safely; absent banks bypass.
    logic [KEY_W-1:0]  w_bank [2**BW];
    logic [2**BW-1:0]  w_ok_pad;

    for (genvar g = 0; g < 2**BW; g++) begin : g_pad
        if (g < NBANK) begin : g_real
            assign w_bank[g]   = w_keys[g*KEY_W +: KEY_W];
            assign w_ok_pad[g] = w_key_ok[g];
        end else begin : g_zero
            assign w_bank[g]   = '0;
            assign w_ok_pad[g] = 1'b0;
        end
    end

    logic [KEY_W-1:0] w_key;
    logic [15:0]      w_a;
    logic [15:0]      w_akey;
    logic [15:0]      w_hit;

    assign w_key  = w_bank[i_key_sel];
    assign w_a    = i_addr[15:0];
    assign w_akey = w_key[AKEY_LSB +: 16];
    assign w_hit  = i_m1_n ? ((w_a ^ DATA_XOR) + w_akey + 16'd1) : (w_a + w_akey);

    logic        r_st1_vld;
    logic        r_st1_byp;
    logic [15:0] r_st1_hit;
    logic [7:0]  r_st1_din;
    logic [31:0] r_st1_s1;
    logic [31:0] r_st1_s2;
    logic [7:0]  r_st1_xkey;
    logic [7:0]  r_dout;
    logic        r_dout_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_st1_vld  <= 1'b0;
            r_st1_byp  <= 1'b1;
            r_st1_hit  <= '0;
            r_st1_din  <= '0;
            r_st1_s1   <= '0;
            r_st1_s2   <= '0;
            r_st1_xkey <= '0;
            r_dout     <= '0;
            r_dout_ok  <= 1'b0;
        end else begin
            r_st1_vld  <= i_req;
            r_st1_byp  <= !i_en || !w_ok_pad[i_key_sel];
            r_st1_hit  <= w_hit;
            r_st1_din  <= i_din;
            r_st1_s1   <= w_key[S1_LSB +: 32];
            r_st1_s2   <= w_key[S2_LSB +: 32];
            r_st1_xkey <= w_key[XKEY_LSB +: 8];
            r_dout_ok  <= r_st1_vld;
            if (r_st1_vld) begin
                r_dout <= r_st1_byp ? r_st1_din
                        : kabuki_cipher(r_st1_din, r_st1_s1, r_st1_s2, r_st1_xkey, r_st1_hit);
            end
        end
    end

    assign o_dout    = r_dout;
    assign o_dout_ok = r_dout_ok;
    assign o_key_ok  = w_key_ok;

endmodule
